pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_ctrl.sv | 92 +++++++++
 tb/tb_pipe_hazard_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: load-use stall, branch flush and memory freeze control for a 5-stage pipeline.
// Optional event counters are built when PIPE_HAZARD_STATS_EN is defined.
module pipe_hazard_ctrl #(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int REG_ADDR_W        = 5
) (
  input  logic                  clock,
  input  logic                  nreset,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_mem_read,
  input  logic                  branch_taken,
  input  logic                  mem_busy,
  output logic                  pc_hold,
  output logic                  if_id_stall,
  output logic                  id_ex_stall,
  output logic                  ex_mem_stall,
  output logic                  if_id_flush,
  output logic                  id_ex_bubble,
  output logic                  take_branch_addr,
  output logic [15:0]           stall_events,
  output logic [15:0]           flush_events
);
  typedef enum logic {RUN, LOAD_STALL} state_t;
  localparam logic [1:0] STALL_INIT = 2'(LOAD_STALL_CYCLES - 1);
  state_t     r_state, w_next_state;
  logic [1:0] r_stall_cnt, w_next_cnt;
  logic       w_hazard, w_live, w_branch, w_load, w_detect;
  assign w_hazard = ex_mem_read && (ex_rd != '0) &&
                    ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
  assign w_live   = nreset && !mem_busy;
  assign w_branch = w_live && branch_taken;
  assign w_load   = w_live && !branch_taken && (r_state == LOAD_STALL || w_hazard);
  assign w_detect = w_load && r_state == RUN;
  always_ff @(posedge clock) begin
    if (!nreset) begin
      r_state     <= RUN;
      r_stall_cnt <= 2'd0;
    end else begin
      r_state     <= w_next_state;
      r_stall_cnt <= w_next_cnt;
    end
  end
  // A frozen pipeline keeps the stall countdown where it is, so bubbles only count live cycles.
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_stall_cnt;
    if (mem_busy) begin
      w_next_state = r_state;
    end else if (branch_taken) begin
      w_next_state = RUN;
      w_next_cnt   = 2'd0;
    end else if (r_state == LOAD_STALL) begin
      w_next_cnt   = r_stall_cnt - 2'd1;
      w_next_state = (r_stall_cnt == 2'd1) ? RUN : LOAD_STALL;
    end else if (w_hazard && LOAD_STALL_CYCLES > 1) begin
      w_next_state = LOAD_STALL;
      w_next_cnt   = STALL_INIT;
    end
  end
  always_comb begin
    pc_hold          = (nreset && mem_busy) || w_load;
    if_id_stall      = (nreset && mem_busy) || w_load;
    id_ex_stall      = nreset && mem_busy;
    ex_mem_stall     = nreset && mem_busy;
    if_id_flush      = !nreset || w_branch;
    id_ex_bubble     = !nreset || w_branch || w_load;
    take_branch_addr = w_branch;
  end
`ifdef PIPE_HAZARD_STATS_EN
  logic [15:0] r_stall_events, r_flush_events;
  always_ff @(posedge clock) begin
    if (!nreset) begin
      r_stall_events <= 16'd0;
      r_flush_events <= 16'd0;
    end else begin
      if (w_detect && r_stall_events != 16'hFFFF) r_stall_events <= r_stall_events + 16'd1;
      if (w_branch && r_flush_events != 16'hFFFF) r_flush_events <= r_flush_events + 16'd1;
    end
  end
  assign stall_events = r_stall_events;
  assign flush_events = r_flush_events;
`else
  logic w_unused;
  assign w_unused     = w_detect;
  assign stall_events = 16'd0;
  assign flush_events = 16'd0;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: checks two instances (1 and 3 bubble cycles) against a bubble-count model.
module tb_pipe_hazard_ctrl;
`ifdef PIPE_HAZARD_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  localparam logic [6:0] C_IDLE = 7'b0000000;
  localparam logic [6:0] C_RST  = 7'b0000110;
  localparam logic [6:0] C_FRZ  = 7'b1111000;
  localparam logic [6:0] C_BR   = 7'b0000111;
  localparam logic [6:0] C_LOAD = 7'b1100010;

  logic clock = 1'b0;
  logic nreset = 1'b0;
  logic [4:0] rs1 = '0, rs2 = '0, rd = '0;
  logic us1 = 0, us2 = 0, mr = 0, br = 0, busy = 0;
  logic ph1, is1, es1, ms1, fl1, bb1, tk1, ph3, is3, es3, ms3, fl3, bb3, tk3;
  logic [15:0] se1, fe1, se3, fe3;
  logic [6:0] c1, c3;
  int n_cmp = 0, n_err = 0;
  int rem1 = 0, rem3 = 0, mse1 = 0, mfe1 = 0, mse3 = 0, mfe3 = 0;

  always #5 clock = ~clock;

  pipe_hazard_ctrl #(.LOAD_STALL_CYCLES(1), .REG_ADDR_W(5)) u1 (
    .clock(clock), .nreset(nreset), .id_rs1(rs1), .id_rs2(rs2), .id_uses_rs1(us1), .id_uses_rs2(us2),
    .ex_rd(rd), .ex_mem_read(mr), .branch_taken(br), .mem_busy(busy),
    .pc_hold(ph1), .if_id_stall(is1), .id_ex_stall(es1), .ex_mem_stall(ms1), .if_id_flush(fl1),
    .id_ex_bubble(bb1), .take_branch_addr(tk1), .stall_events(se1), .flush_events(fe1));
  pipe_hazard_ctrl #(.LOAD_STALL_CYCLES(3), .REG_ADDR_W(5)) u3 (
    .clock(clock), .nreset(nreset), .id_rs1(rs1), .id_rs2(rs2), .id_uses_rs1(us1), .id_uses_rs2(us2),
    .ex_rd(rd), .ex_mem_read(mr), .branch_taken(br), .mem_busy(busy),
    .pc_hold(ph3), .if_id_stall(is3), .id_ex_stall(es3), .ex_mem_stall(ms3), .if_id_flush(fl3),
    .id_ex_bubble(bb3), .take_branch_addr(tk3), .stall_events(se3), .flush_events(fe3));

  assign c1 = {ph1, is1, es1, ms1, fl1, bb1, tk1};
  assign c3 = {ph3, is3, es3, ms3, fl3, bb3, tk3};

  // Model: rem = live bubble cycles still owed for the current load-use hazard.
  function automatic logic hz();
    return mr && rd != 0 && ((us1 && rs1 == rd) || (us2 && rs2 == rd));
  endfunction
  function automatic logic [6:0] exp_ctrl(int rem);
    if (!nreset) return C_RST;
    if (busy) return C_FRZ;
    if (br) return C_BR;
    if (rem > 0 || hz()) return C_LOAD;
    return C_IDLE;
  endfunction
  function automatic int nrem(int rem, int lsc);
    if (!nreset) return 0;
    if (busy) return rem;
    if (br) return 0;
    if (rem > 0) return rem - 1;
    if (hz()) return lsc - 1;
    return 0;
  endfunction
  function automatic int nse(int rem, int se);
    if (!nreset) return 0;
    if (busy || br) return se;
    if (rem == 0 && hz()) return se < 65535 ? se + 1 : se;
    return se;
  endfunction
  function automatic int nfe(int fe);
    if (!nreset) return 0;
    if (!busy && br) return fe < 65535 ? fe + 1 : fe;
    return fe;
  endfunction
  function automatic logic [15:0] ecnt(int v);
    return STATS ? 16'(v) : 16'd0;
  endfunction

  always @(posedge clock) begin
    rem1 <= nrem(rem1, 1);
    rem3 <= nrem(rem3, 3);
    mse1 <= nse(rem1, mse1);
    mse3 <= nse(rem3, mse3);
    mfe1 <= nfe(mfe1);
    mfe3 <= nfe(mfe3);
  end

  task automatic clear_in();
    rs1 = 0; rs2 = 0; rd = 0; us1 = 0; us2 = 0; mr = 0; br = 0; busy = 0;
  endtask
  task automatic set_hazard();
    rs1 = 5; us1 = 1; rs2 = 9; us2 = 0; rd = 5; mr = 1; br = 0; busy = 0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      nreset = 0; set_hazard(); br = i[0]; busy = i[1];
      #2;
      n_cmp += 2;
      if (c1 !== C_RST) begin n_err++; $display("FAIL reset_ctrl1 got %b want %b", c1, C_RST); end
      if (c3 !== C_RST) begin n_err++; $display("FAIL reset_ctrl3 got %b want %b", c3, C_RST); end
    end
    @(negedge clock); clear_in(); nreset = 1; #2;
    n_cmp += 3;
    if (c1 !== C_IDLE) begin n_err++; $display("FAIL reset_release1 got %b want %b", c1, C_IDLE); end
    if (c3 !== C_IDLE) begin n_err++; $display("FAIL reset_release3 got %b want %b", c3, C_IDLE); end
    if ({se1, fe1, se3, fe3} !== 64'd0) begin n_err++; $display("FAIL reset_counters got %h want 0", {se1, fe1, se3, fe3}); end
  endtask

  task automatic test_single_load();
    logic [6:0] w1 [4] = '{C_LOAD, C_IDLE, C_IDLE, C_IDLE};
    logic [6:0] w3 [4] = '{C_LOAD, C_LOAD, C_LOAD, C_IDLE};
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      if (i == 0) set_hazard(); else clear_in();
      #2;
      n_cmp += 2;
      if (c1 !== w1[i]) begin n_err++; $display("FAIL single_load1[%0d] got %b want %b", i, c1, w1[i]); end
      if (c3 !== w3[i]) begin n_err++; $display("FAIL single_load3[%0d] got %b want %b", i, c3, w3[i]); end
    end
  endtask

  task automatic test_busy_during_stall();
    logic [6:0] w1 [6] = '{C_LOAD, C_FRZ, C_FRZ, C_IDLE, C_IDLE, C_IDLE};
    logic [6:0] w3 [6] = '{C_LOAD, C_FRZ, C_FRZ, C_LOAD, C_LOAD, C_IDLE};
    int bubbles = 0, frozen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      if (i == 0) set_hazard(); else clear_in();
      busy = (i == 1 || i == 2);
      #2;
      bubbles += bb3;
      frozen += (ph3 && is3 && es3 && ms3);
      n_cmp += 2;
      if (c1 !== w1[i]) begin n_err++; $display("FAIL busy_stall1[%0d] got %b want %b", i, c1, w1[i]); end
      if (c3 !== w3[i]) begin n_err++; $display("FAIL busy_stall3[%0d] got %b want %b", i, c3, w3[i]); end
    end
    n_cmp += 2;
    if (bubbles != 3) begin n_err++; $display("FAIL busy_bubble_total got %0d want 3", bubbles); end
    if (frozen != 2) begin n_err++; $display("FAIL busy_frozen_total got %0d want 2", frozen); end
  endtask

  task automatic test_branch();
    logic [6:0] w3 [5] = '{C_BR, C_IDLE, C_LOAD, C_BR, C_IDLE};
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      clear_in();
      if (i == 0 || i == 2) set_hazard();
      br = (i == 0 || i == 3);
      if (i == 0) begin mr = 1; rd = 5; end
      #2;
      n_cmp++;
      if (c3 !== w3[i]) begin n_err++; $display("FAIL branch3[%0d] got %b want %b", i, c3, w3[i]); end
      if (i == 0) begin
        n_cmp++;
        if (c1 !== C_BR) begin n_err++; $display("FAIL branch1 got %b want %b", c1, C_BR); end
      end
    end
  endtask

  task automatic test_rd_zero();
    @(negedge clock);
    clear_in(); mr = 1; rd = 0; rs1 = 0; us1 = 1; rs2 = 0; us2 = 1;
    #2;
    n_cmp += 2;
    if (c1 !== C_IDLE) begin n_err++; $display("FAIL rd_zero1 got %b want %b", c1, C_IDLE); end
    if (c3 !== C_IDLE) begin n_err++; $display("FAIL rd_zero3 got %b want %b", c3, C_IDLE); end
  endtask

  task automatic test_reset_mid_stall();
    @(negedge clock); set_hazard();
    @(negedge clock); clear_in(); nreset = 0; #2;
    n_cmp++;
    if (c3 !== C_RST) begin n_err++; $display("FAIL mid_stall_reset got %b want %b", c3, C_RST); end
    for (int i = 0; i < 2; i++) begin
      @(negedge clock); nreset = 1; clear_in(); #2;
      n_cmp += 2;
      if (c3 !== C_IDLE) begin n_err++; $display("FAIL mid_stall_release3[%0d] got %b want %b", i, c3, C_IDLE); end
      if (c1 !== C_IDLE) begin n_err++; $display("FAIL mid_stall_release1[%0d] got %b want %b", i, c1, C_IDLE); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clock);
      nreset = ($urandom_range(0, 49) != 0);
      rs1 = 5'($urandom_range(0, 3)); rs2 = 5'($urandom_range(0, 3)); rd = 5'($urandom_range(0, 3));
      us1 = $urandom_range(0, 1) == 1; us2 = $urandom_range(0, 1) == 1; mr = $urandom_range(0, 1) == 1;
      br = $urandom_range(0, 7) == 0; busy = $urandom_range(0, 5) == 0;
      #2;
      n_cmp += 6;
      if (c1 !== exp_ctrl(rem1)) begin n_err++; $display("FAIL rand_ctrl1[%0d] got %b want %b", i, c1, exp_ctrl(rem1)); end
      if (c3 !== exp_ctrl(rem3)) begin n_err++; $display("FAIL rand_ctrl3[%0d] got %b want %b", i, c3, exp_ctrl(rem3)); end
      if (se1 !== ecnt(mse1)) begin n_err++; $display("FAIL rand_stall_ev1[%0d] got %0d want %0d", i, se1, ecnt(mse1)); end
      if (fe1 !== ecnt(mfe1)) begin n_err++; $display("FAIL rand_flush_ev1[%0d] got %0d want %0d", i, fe1, ecnt(mfe1)); end
      if (se3 !== ecnt(mse3)) begin n_err++; $display("FAIL rand_stall_ev3[%0d] got %0d want %0d", i, se3, ecnt(mse3)); end
      if (fe3 !== ecnt(mfe3)) begin n_err++; $display("FAIL rand_flush_ev3[%0d] got %0d want %0d", i, fe3, ecnt(mfe3)); end
    end
  endtask

  task automatic test_saturation();
    @(negedge clock); clear_in(); nreset = 0;
    @(negedge clock); nreset = 1; br = 1;
    @(negedge clock); set_hazard();
    if (STATS) repeat (70000) @(negedge clock);
    else repeat (50) @(negedge clock);
    #2;
    n_cmp += 5;
    if (se1 !== (STATS ? 16'hFFFF : 16'd0)) begin n_err++; $display("FAIL sat_stall_ev1 got %h want %h", se1, STATS ? 16'hFFFF : 16'd0); end
    if (se1 !== ecnt(mse1)) begin n_err++; $display("FAIL sat_model_ev1 got %0d want %0d", se1, ecnt(mse1)); end
    if (se3 !== ecnt(mse3)) begin n_err++; $display("FAIL sat_model_ev3 got %0d want %0d", se3, ecnt(mse3)); end
    if (fe1 !== (STATS ? 16'd1 : 16'd0)) begin n_err++; $display("FAIL sat_flush_ev1 got %0d want %0d", fe1, STATS ? 1 : 0); end
    if (fe3 !== ecnt(mfe3)) begin n_err++; $display("FAIL sat_flush_ev3 got %0d want %0d", fe3, ecnt(mfe3)); end
  endtask

  initial begin
    test_reset();
    test_single_load();
    test_busy_during_stall();
    test_branch();
    test_rd_zero();
    test_reset_mid_stall();
    test_random();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
